aemb2_iche: RTL

AEMB2_ICHE -- requirements
Module: aeMB2_iche

---
 rtl/aemb2_iche.sv | 118 +++++++++++
 1 files changed

// File: rtl/aemb2_iche.sv
// Direct-mapped, one-word-line instruction cache for the aeMB2 fetch stage.
// Fills from the instruction bus on ack; whole-cache flush walks every line once.
module aemb2_iche #(
  parameter int AEMB_IWB = 32,
  parameter int AEMB_ICH = 11,
  parameter int AEMB_HTX = 1
) (
  input  logic                  gclk,
  input  logic                  grst,
  input  logic                  iena,
  input  logic [AEMB_IWB-1:2]   ich_adr,
  input  logic                  iwb_ack_i,
  input  logic [31:0]           iwb_dat_i,
  input  logic                  ich_fls,
  input  logic                  ich_inv,
  input  logic [AEMB_IWB-1:2]   ich_iadr,
  output logic                  ich_hit,
  output logic [31:0]           ich_dat,
  output logic                  ich_bsy
);

  localparam int TAG_W = AEMB_IWB - 2 - AEMB_ICH;
  localparam int LINES = 1 << AEMB_ICH;
  localparam logic [AEMB_ICH-1:0] CNT_LAST = '1;

  if (AEMB_ICH < 1 || TAG_W < 1 || AEMB_HTX < 0) begin : g_bad_param
    $error("aemb2_iche: unsupported parameter combination");
  end

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  state_t              r_state;
  logic [AEMB_ICH-1:0] r_cnt;
  logic [LINES-1:0]    r_val;
  logic [TAG_W-1:0]    r_tag [LINES];
  logic [31:0]         r_dat [LINES];
  logic [31:0]         r_out;

  logic [AEMB_ICH-1:0] w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic [AEMB_ICH-1:0] w_iidx;
  logic [TAG_W-1:0]    w_itag;
  logic                w_fill;
  logic                w_inv;

  assign w_idx  = ich_adr[AEMB_ICH+1:2];
  assign w_tag  = ich_adr[AEMB_IWB-1:AEMB_ICH+2];
  assign w_iidx = ich_iadr[AEMB_ICH+1:2];
  assign w_itag = ich_iadr[AEMB_IWB-1:AEMB_ICH+2];

  assign ich_bsy = (r_state == S_FLUSH);
  assign ich_hit = r_val[w_idx] && (r_tag[w_idx] == w_tag) && !ich_bsy;
  assign w_fill  = iwb_ack_i && !ich_bsy && !grst;
  assign w_inv   = ich_inv && !ich_bsy && (r_tag[w_iidx] == w_itag);
  assign ich_dat = r_out;

  // NOTE: all sequential state uses non-blocking assignments so every block
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge gclk) begin
    if (grst) begin
      r_state <= S_FLUSH;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ich_fls) begin
            r_state <= S_FLUSH;
            r_cnt   <= '0;
          end
        end
        S_FLUSH: begin
          if (ich_fls) begin
            r_cnt <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_FLUSH;
      endcase
    end
  end

  // Valid bits are cleared only by the flush walk, never by grst directly.
  always_ff @(posedge gclk) begin
    if (!grst) begin
      if (r_state == S_FLUSH) begin
        r_val[r_cnt] <= 1'b0;
      end else begin
        if (w_fill) r_val[w_idx] <= 1'b1;
        // Later assignment to the same bit wins, so invalidate beats fill.
        if (w_inv) r_val[w_iidx] <= 1'b0;
      end
    end
  end

  // NOTE: tag and data arrays carry no reset; the valid bits alone decide
  // whether their contents mean anything, which keeps them plain RAM.
  always_ff @(posedge gclk) begin
    if (w_fill) begin
      r_tag[w_idx] <= w_tag;
      r_dat[w_idx] <= iwb_dat_i;
    end
  end

  always_ff @(posedge gclk) begin
    if (grst) begin
      r_out <= '0;
    end else if (iena) begin
      r_out <= iwb_ack_i ? iwb_dat_i : r_dat[w_idx];
    end
  end

endmodule
